uart_frame_sched: RTL

Command-driven scheduler that sits between the byte UART (RX/TX byte interface) and the camera frame RAM. It decodes single-byte host commands from the UART receiver and answers ping/unknown commands. On request it streams a whole frame from RAM to the UART transmitter, framed by a header and a checksum. It paces the TX side purely by timing, because the UART exposes no busy/ack, and it freezes camera writes while a dump is in progress.

---
 rtl/uart_frame_sched.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_sched.sv
// uart_frame_sched
//   Decodes single-byte host commands from the UART receiver and schedules the
//   bytes handed to the UART transmitter. It answers ping and unknown commands
//   with one byte. On a dump request it streams a header, the whole frame from
//   RAM, and a modulo-256 checksum. The UART gives no busy/ack, so bytes are
//   paced purely by a slot counter of BYTE_GAP clocks.
//
// Ports
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   rx_data      received byte, valid while rx_valid is high
//   rx_valid     receive flag; a rising edge carries exactly one command
//   tx_ready     byte strobe to UART TX, high for HOLD clocks per slot
//   tx_data      byte to transmit; loaded one clock before the strobe
//   ram_addr     frame RAM read address
//   ram_rd_en    one-clock read strobe
//   ram_rdata    read data, sampled one clock after ram_rd_en
//   cam_freeze   high while a dump owns the frame RAM
//   busy         high whenever the scheduler is not idle
//   done         one-clock pulse when a dump completes or is aborted
module uart_frame_sched #(
   parameter int FRAME_LEN = 4800,
   parameter int ADDR_W    = 13,
   parameter int BYTE_GAP  = 325,
   parameter int HOLD      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd_en,
   input  logic [7:0]        ram_rdata,
   output logic              cam_freeze,
   output logic              busy,
   output logic              done
);

   localparam int OFF_W = $clog2(BYTE_GAP);
   localparam int IDX_W = ADDR_W + 1;

   // Slot offsets: prefetch strobe, next-byte load, and last clock of a slot.
   localparam logic [OFF_W-1:0] OFF_PF   = OFF_W'(BYTE_GAP - 3);
   localparam logic [OFF_W-1:0] OFF_LOAD = OFF_W'(BYTE_GAP - 2);
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BYTE_GAP - 1);
   localparam logic [OFF_W-1:0] OFF_HOLD = OFF_W'(HOLD);
   localparam logic [IDX_W-1:0] FRAME_CNT = IDX_W'(FRAME_LEN);

   localparam logic [7:0] CMD_PING    = 8'h01;
   localparam logic [7:0] CMD_DUMP    = 8'h02;
   localparam logic [7:0] CMD_ABORT   = 8'h03;
   localparam logic [7:0] RSP_PING    = 8'hA5;
   localparam logic [7:0] RSP_ABORT   = 8'hEE;
   localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
   localparam logic [7:0] HDR_0       = 8'hAA;
   localparam logic [7:0] HDR_1       = 8'h55;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESP,
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_ABRT
   } state_t;

   state_t             state_q;
   logic               rx_prev_q;
   logic               cmd_vld_q;
   logic [7:0]         cmd_q;
   logic [OFF_W-1:0]   off_q;
   logic               started_q;
   logic               abort_q;
   logic               pf_q;
   logic [IDX_W-1:0]   rd_idx_q;
   logic [7:0]         csum_q;

   logic               cmd_stb_d;
   logic [OFF_W-1:0]   off_d;
   logic               strobe_d;
   logic               abort_now;
   logic               abort_eff;
   logic               at_pf;
   logic               at_load;
   logic               at_wrap;

   always_comb begin
      cmd_stb_d = rx_valid & ~rx_prev_q;
      off_d     = (off_q == OFF_LAST) ? '0 : off_q + OFF_W'(1);
      strobe_d  = (off_d < OFF_HOLD);
      at_pf     = (off_q == OFF_PF);
      at_load   = (off_q == OFF_LOAD);
      at_wrap   = (off_q == OFF_LAST);
      // Abort is only honoured while header or data are still being sent.
      abort_now = cmd_vld_q && (cmd_q == CMD_ABORT) &&
                  ((state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA));
      abort_eff = abort_q | abort_now;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rx_prev_q  <= 1'b0;
         cmd_vld_q  <= 1'b0;
         cmd_q      <= 8'h00;
         off_q      <= '0;
         started_q  <= 1'b0;
         abort_q    <= 1'b0;
         pf_q       <= 1'b0;
         rd_idx_q   <= '0;
         csum_q     <= 8'h00;
         tx_ready   <= 1'b0;
         tx_data    <= 8'h00;
         ram_addr   <= '0;
         ram_rd_en  <= 1'b0;
         cam_freeze <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         rx_prev_q <= rx_valid;
         cmd_vld_q <= cmd_stb_d;
         if (cmd_stb_d) begin
            cmd_q <= rx_data;
         end
         ram_rd_en <= 1'b0;
         done      <= 1'b0;

         if (state_q != S_IDLE) begin
            off_q    <= off_d;
            tx_ready <= strobe_d;
            // started_q marks that the current byte's slot has begun, so the
            // wrap that opens a slot is not mistaken for the one that ends it.
            if (at_wrap) begin
               started_q <= 1'b1;
            end
         end

         if (abort_now) begin
            abort_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               tx_ready <= 1'b0;
               abort_q  <= 1'b0;
               pf_q     <= 1'b0;
               if (cmd_vld_q) begin
                  busy      <= 1'b1;
                  // Enter at the last offset so the strobe rises on the next clock.
                  off_q     <= OFF_LAST;
                  started_q <= 1'b0;
                  case (cmd_q)
                     CMD_PING: begin
                        state_q <= S_RESP;
                        tx_data <= RSP_PING;
                     end
                     CMD_DUMP: begin
                        state_q    <= S_HDR0;
                        tx_data    <= HDR_0;
                        cam_freeze <= 1'b1;
                        csum_q     <= 8'h00;
                        rd_idx_q   <= '0;
                     end
                     CMD_ABORT: begin
                        state_q <= S_RESP;
                        tx_data <= RSP_ABORT;
                     end
                     default: begin
                        state_q <= S_RESP;
                        tx_data <= RSP_UNKNOWN;
                     end
                  endcase
               end
            end

            S_HDR0: begin
               if (at_load) begin
                  started_q <= 1'b0;
                  if (abort_eff) begin
                     state_q <= S_ABRT;
                     tx_data <= RSP_ABORT;
                  end else begin
                     state_q <= S_HDR1;
                     tx_data <= HDR_1;
                  end
               end
            end

            S_HDR1, S_DATA: begin
               // Prefetch the next data byte so it is on ram_rdata at the load.
               if (at_pf && !abort_eff && (rd_idx_q < FRAME_CNT)) begin
                  ram_rd_en <= 1'b1;
                  ram_addr  <= rd_idx_q[ADDR_W-1:0];
                  rd_idx_q  <= rd_idx_q + IDX_W'(1);
                  pf_q      <= 1'b1;
               end
               if (at_load) begin
                  started_q <= 1'b0;
                  pf_q      <= 1'b0;
                  if (abort_eff) begin
                     state_q <= S_ABRT;
                     tx_data <= RSP_ABORT;
                  end else if (pf_q) begin
                     state_q <= S_DATA;
                     tx_data <= ram_rdata;
                     csum_q  <= csum_q + ram_rdata;
                  end else begin
                     // No prefetch this slot: the frame is exhausted.
                     state_q <= S_CSUM;
                     tx_data <= csum_q;
                  end
               end
            end

            S_RESP, S_CSUM, S_ABRT: begin
               if (at_wrap && started_q) begin
                  state_q    <= S_IDLE;
                  tx_ready   <= 1'b0;
                  busy       <= 1'b0;
                  cam_freeze <= 1'b0;
                  done       <= (state_q != S_RESP);
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
